// File: rtl/iommu_wsi_ig_mc_if.sv
// Purpose : bundles the WSI generator's control, pending/vector inputs and wire outputs.
// Latency : none (signal bundle only).
// Backpress: none; the generator has no flow control and accepts inputs every cycle.
//
// Ports (signals):
//   wsi_en_i     generation enable (fctl.wsi)
//   edge_mode_i  0 = level, 1 = edge/pulse mode
//   ip_i         N_SRC pending bits from ipsr
//   iv_i         per-source wire vector, source s at [s*VEC_W +: VEC_W]
//   wsi_wires_o  registered interrupt wires
//   wire_busy_o  per-wire pulse FSM not idle (edge mode)
// Modports: slave = generator side, master = register-file / platform side.
interface iommu_wsi_ig_mc_if #(
  parameter int N_SRC   = 3,
  parameter int N_WIRES = 16
);
  localparam int VEC_W = $clog2(N_WIRES);

  logic                     wsi_en_i;
  logic                     edge_mode_i;
  logic [N_SRC-1:0]         ip_i;
  logic [N_SRC*VEC_W-1:0]   iv_i;
  logic [N_WIRES-1:0]       wsi_wires_o;
  logic [N_WIRES-1:0]       wire_busy_o;

  modport slave (
    input  wsi_en_i,
    input  edge_mode_i,
    input  ip_i,
    input  iv_i,
    output wsi_wires_o,
    output wire_busy_o
  );

  modport master (
    output wsi_en_i,
    output edge_mode_i,
    output ip_i,
    output iv_i,
    input  wsi_wires_o,
    input  wire_busy_o
  );
endinterface

// File: rtl/iommu_wsi_ig_mc.sv
// Purpose : maps N_SRC IOMMU pending bits onto N_WIRES wired-signal interrupt lines (level or pulse).
// Latency : 1 cycle from ip_i/iv_i to wsi_wires_o in both modes.
// Backpress: none; events arriving while a wire is pulsing collapse into one pending re-pulse.
//
// Ports:
//   clk_i   clock (single domain)
//   rst_i   synchronous, active-high reset
//   wsi     iommu_wsi_ig_mc_if.slave: wsi_en_i, edge_mode_i, ip_i, iv_i in;
//           wsi_wires_o, wire_busy_o out (both registered)
// Build option: WSI_IG_HOLDOFF_EN -- when defined the low gap between pulses on one wire is
//   HOLDOFF_CYC cycles, otherwise it is a single cycle.
module iommu_wsi_ig_mc #(
  parameter int N_SRC       = 3,
  parameter int N_WIRES     = 16,
  parameter int PULSE_CYC   = 4,
  parameter int HOLDOFF_CYC = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  iommu_wsi_ig_mc_if.slave   wsi
);

  localparam int VEC_W = $clog2(N_WIRES);

`ifdef WSI_IG_HOLDOFF_EN
  localparam int GAP_CYC = HOLDOFF_CYC;
`else
  // HOLDOFF_CYC has no effect in this build; the gap is one cycle.
  localparam int GAP_CYC = 1 + 0 * HOLDOFF_CYC;
`endif

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } wire_st_e;

  // Per-wire pulse FSM state
  wire_st_e           st_q   [N_WIRES];
  wire_st_e           st_d   [N_WIRES];
  logic [CNT_W-1:0]   cnt_q  [N_WIRES];
  logic [CNT_W-1:0]   cnt_d  [N_WIRES];
  logic [N_WIRES-1:0] pend_q, pend_d;

  logic [N_SRC-1:0]   ip_q, ip_d;
  logic               mode_q;
  logic [N_WIRES-1:0] wire_q, wire_d;
  logic [N_WIRES-1:0] busy_q, busy_d;

  // Source-to-wire mapping
  logic [N_SRC-1:0]   evt;
  logic [N_WIRES-1:0] lvl_hit;
  logic [N_WIRES-1:0] evt_hit;
  logic [VEC_W-1:0]   vec;

  // Out-of-range vectors simply never compare equal to any existing wire index.
  // Events from several sources on one wire OR together into a single event.
  always_comb begin
    evt     = wsi.ip_i & ~ip_q;
    lvl_hit = '0;
    evt_hit = '0;
    vec     = '0;
    for (int s = 0; s < N_SRC; s++) begin
      vec = wsi.iv_i[s*VEC_W +: VEC_W];
      for (int w = 0; w < N_WIRES; w++) begin
        if (vec == VEC_W'(w)) begin
          lvl_hit[w] = lvl_hit[w] | wsi.ip_i[s];
          evt_hit[w] = evt_hit[w] | evt[s];
        end
      end
    end
  end

  logic mode_chg;

  // Next-state / output decode for all wires
  always_comb begin
    mode_chg = wsi.edge_mode_i ^ mode_q;
    // ip_q tracks ip_i only while enabled so that sources already pending at enable
    // rise look like fresh events.
    ip_d     = wsi.wsi_en_i ? wsi.ip_i : '0;
    pend_d   = '0;
    wire_d   = '0;
    busy_d   = '0;
    for (int w = 0; w < N_WIRES; w++) begin
      st_d[w]  = ST_IDLE;
      cnt_d[w] = '0;
    end

    if (wsi.wsi_en_i && !wsi.edge_mode_i) begin
      // Level mode (also the cycle the mode flips to level): FSMs stay idle.
      wire_d = lvl_hit;
    end else if (wsi.wsi_en_i && !mode_chg) begin
      // Edge mode. A flip into edge mode leaves everything idle for that cycle.
      for (int w = 0; w < N_WIRES; w++) begin
        case (st_q[w])
          ST_IDLE: begin
            if (evt_hit[w]) begin
              st_d[w]  = ST_PULSE;
              cnt_d[w] = PULSE_LD;
            end
          end
          ST_PULSE: begin
            pend_d[w] = pend_q[w] | evt_hit[w];
            if (cnt_q[w] == '0) begin
              st_d[w]  = ST_GAP;
              cnt_d[w] = GAP_LD;
            end else begin
              st_d[w]  = ST_PULSE;
              cnt_d[w] = cnt_q[w] - CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cnt_q[w] == '0) begin
              // An event landing in the last gap cycle launches the next pulse directly.
              if (pend_q[w] || evt_hit[w]) begin
                st_d[w]  = ST_PULSE;
                cnt_d[w] = PULSE_LD;
              end
            end else begin
              st_d[w]   = ST_GAP;
              cnt_d[w]  = cnt_q[w] - CNT_W'(1);
              pend_d[w] = pend_q[w] | evt_hit[w];
            end
          end
          default: begin
            st_d[w] = ST_IDLE;
          end
        endcase
        wire_d[w] = (st_d[w] == ST_PULSE);
        busy_d[w] = (st_d[w] != ST_IDLE);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // mode_q follows the pin even in reset so leaving reset is never seen as a mode flip.
    mode_q <= wsi.edge_mode_i;
    if (rst_i) begin
      ip_q   <= '0;
      pend_q <= '0;
      wire_q <= '0;
      busy_q <= '0;
      for (int w = 0; w < N_WIRES; w++) begin
        st_q[w]  <= ST_IDLE;
        cnt_q[w] <= '0;
      end
    end else begin
      ip_q   <= ip_d;
      pend_q <= pend_d;
      wire_q <= wire_d;
      busy_q <= busy_d;
      for (int w = 0; w < N_WIRES; w++) begin
        st_q[w]  <= st_d[w];
        cnt_q[w] <= cnt_d[w];
      end
    end
  end

  assign wsi.wsi_wires_o = wire_q;
  assign wsi.wire_busy_o = busy_q;

endmodule
